alu_issue_sequencer: RTL
========================

Name: alu_issue_sequencer

Overview:
- Front-end controller for the 32-bit combinational ALU.
- Accepts decoded MIPS-style instruction fields plus register operands over a valid/ready handshake.
- Generates the ALU's 11-bit op_ctl bus and A/B operands, waits a programmable settle time, captures result and flags, and returns them over a second valid/ready handshake.
- Sits between the register-read stage and writeback; the ALU itself is instantiated externally and wired to the alu_* ports.

Parameters:
- EXEC_CYCLES, 1, ALU settle cycles between operand issue and capture (1..15).
- TRAP_EN, 1, when 1, overflow on signed add/sub/addi raises out_ovf_trap.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  sequencer can accept a request.
- in_opcode  in  6  instruction opcode.
- in_funct  in  6  R-type funct.
- in_shamt  in  5  R-type shift amount.
- in_rs  in  32  rs operand value.
- in_rt  in  32  rt operand value.
- in_imm  in  16  I-type immediate.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_op_ctl  out  11  {shamt[4:0], ctl[5:0]} to ALU.
- alu_z  in  32  ALU result.
- alu_overflow  in  1  ALU overflow flag.
- alu_zero  in  1  ALU zero flag.
- alu_carryout  in  1  ALU carry-out flag.
- out_valid  out  1  response valid.
- out_ready  in  1  consumer accepts response.
- out_result  out  32  captured result.
- out_zero  out  1  captured zero flag.
- out_carry  out  1  captured carry-out.
- out_ovf_trap  out  1  signed overflow trap.
- out_illegal  out  1  unsupported opcode/funct.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset state: IDLE.
  - All out_* = 0; in_ready = 1.
  - alu_a = alu_b = 0; alu_op_ctl = 0.
  - Settle counter = 0.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: in_ready=1. A request is accepted when in_valid&&in_ready. The decoded operands and op_ctl are registered onto alu_*.
    - Legal request → EXEC, with counter loaded to EXEC_CYCLES-1.
    - Illegal request → RESP directly, with out_result=0 and out_illegal=1. The alu_* outputs are left unchanged.
  - EXEC: in_ready=0. The counter decrements each cycle. When the counter is 0, the sequencer captures alu_z, alu_zero and alu_carryout, computes out_ovf_trap, and moves to RESP.
  - RESP: out_valid=1 and the out_* outputs are held stable. When out_ready=1, the response handshake completes, out_valid drops next cycle, and the FSM returns to IDLE.
    - Back-to-back: no request is accepted in the RESP cycle.
- Latency (EXEC_CYCLES=1): accept at cycle T, out_valid asserted at T+2. Minimum issue interval is 3 cycles.
- Decode: the ALU ctl code equals the MIPS funct code. The sequencer drives alu_op_ctl[5:0] as follows:
  - R-type (opcode 0x00): A=rs, B=rt, op_ctl={in_shamt, funct}. Accepted funct values are 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x2B sltu.
  - Shifts shift operand A, so rt is routed to A:
    - sll 0x00: A=rt, op_ctl={in_shamt, 0x00}.
    - srl 0x02: A=rt, op_ctl={in_shamt, 0x02}.
    - sllv 0x04: A=rt, op_ctl={rs[4:0], 0x00}.
    - srlv 0x06: A=rt, op_ctl={rs[4:0], 0x02}.
    - B=0 for all shifts.
  - I-type: A=rs, B=ext(imm), shamt=0.
    - 0x08 addi → 0x20, sign-extended.
    - 0x09 addiu → 0x21, sign-extended.
    - 0x0A slti → 0x2A, sign-extended.
    - 0x0B sltiu → 0x2B, sign-extended.
    - 0x0C andi → 0x24, zero-extended.
    - 0x0D ori → 0x25, zero-extended.
    - 0x0E xori → 0x26, zero-extended.
    - 0x0F lui: A=zero-ext imm, B=0, op_ctl={5'd16, 0x00}.
  - Any other opcode or funct → illegal.
- Trap: out_ovf_trap = TRAP_EN && alu_overflow && op ∈ {add, sub, addi}. addu, subu and addiu never trap. On a trap, out_result still carries the wrapped sum.
- Reset mid-operation: rst_n low in EXEC or RESP aborts the operation. The next cycle is IDLE with all outputs at their reset values, and the pending response is discarded.
- in_valid while not in IDLE is ignored; the requester holds the request until in_ready.
- out_ready high with out_valid low has no effect.

Test Plan:
- add rs=0x7FFFFFFF, rt=1 → alu_op_ctl=0x020, out_result=0x80000000, out_ovf_trap=1. The same operands with addu → trap=0.
- sub rs=5, rt=5 → out_result=0, out_zero=1, out_valid at T+2. With out_ready held low 4 cycles, outputs stay stable, then the FSM returns to IDLE after the handshake.
- sllv rs=4, rt=0x1 → alu_op_ctl={5'd4, 6'h00}, alu_a=1, out_result=0x10. lui imm=0xABCD → out_result=0xABCD0000.
- slti rs=0xFFFFFFFF, imm=0x0000 → 1; sltiu with the same operands → 0. andi rs=0xFFFFFFFF, imm=0x8001 → 0x00008001.
- opcode 0x23 (lw) → RESP one cycle after accept, out_illegal=1, out_result=0.
- EXEC_CYCLES=3 → out_valid at T+4. rst_n=0 at T+2 → no out_valid, in_ready=1 at T+3.

Source files
------------

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: front-end controller for an external 32-bit
// combinational ALU. It decodes MIPS-style instruction fields into ALU
// operands and an op_ctl word, waits EXEC_CYCLES for the ALU to settle,
// captures result/flags and returns them over a valid/ready handshake.
module alu_issue_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter bit          TRAP_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [15:0] in_imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [10:0] alu_op_ctl,
  input  logic [31:0] alu_z,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  input  logic        alu_carryout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_carry,
  output logic        out_ovf_trap,
  output logic        out_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        trap_op_q;

  logic        dec_legal;
  logic        dec_trap_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_shamt;
  logic [5:0]  dec_ctl;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        accept;

  assign imm_sext = {{16{in_imm[15]}}, in_imm};
  assign imm_zext = {16'h0000, in_imm};
  assign accept   = in_valid && in_ready;

  // Decode instruction fields into ALU operands, control code and legality.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_legal   = 1'b1;
    dec_trap_op = 1'b0;
    dec_a       = in_rs;
    dec_b       = in_rt;
    dec_shamt   = in_shamt;
    dec_ctl     = in_funct;
    case (in_opcode)
      6'h00: begin
        case (in_funct)
          6'h20, 6'h22: dec_trap_op = 1'b1;
          6'h21, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, 6'h2B: ;
          // Shifts operate on operand A, so rt is routed there.
          6'h00, 6'h02: begin
            dec_a = in_rt;
            dec_b = '0;
          end
          6'h04, 6'h06: begin
            dec_a     = in_rt;
            dec_b     = '0;
            dec_shamt = in_rs[4:0];
            dec_ctl   = (in_funct == 6'h04) ? 6'h00 : 6'h02;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin dec_b = imm_sext; dec_shamt = '0; dec_ctl = 6'h20; dec_trap_op = 1'b1; end
      6'h09: begin dec_b = imm_sext; dec_shamt = '0; dec_ctl = 6'h21; end
      6'h0A: begin dec_b = imm_sext; dec_shamt = '0; dec_ctl = 6'h2A; end
      6'h0B: begin dec_b = imm_sext; dec_shamt = '0; dec_ctl = 6'h2B; end
      6'h0C: begin dec_b = imm_zext; dec_shamt = '0; dec_ctl = 6'h24; end
      6'h0D: begin dec_b = imm_zext; dec_shamt = '0; dec_ctl = 6'h25; end
      6'h0E: begin dec_b = imm_zext; dec_shamt = '0; dec_ctl = 6'h26; end
      // lui is a left shift of the zero-extended immediate by 16.
      6'h0F: begin dec_a = imm_zext; dec_b = '0; dec_shamt = 5'd16; dec_ctl = 6'h00; end
      default: dec_legal = 1'b0;
    endcase
  end

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = dec_legal ? S_EXEC : S_RESP;
      S_EXEC:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_RESP);
  end

  // Operand issue, settle counter and response capture.
  // NOTE: the datapath registers are reset as well, since a mid-operation
  // reset must discard the pending response and return visible zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op_ctl   <= '0;
      cnt          <= '0;
      trap_op_q    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_carry    <= 1'b0;
      out_ovf_trap <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (dec_legal) begin
              alu_a      <= dec_a;
              alu_b      <= dec_b;
              alu_op_ctl <= {dec_shamt, dec_ctl};
              cnt        <= 4'(EXEC_CYCLES - 1);
              trap_op_q  <= TRAP_EN && dec_trap_op;
            end else begin
              // Illegal requests skip the ALU; its operands stay untouched.
              out_result   <= '0;
              out_zero     <= 1'b0;
              out_carry    <= 1'b0;
              out_ovf_trap <= 1'b0;
              out_illegal  <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_result   <= alu_z;
            out_zero     <= alu_zero;
            out_carry    <= alu_carryout;
            out_ovf_trap <= trap_op_q && alu_overflow;
            out_illegal  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
